// File: rtl/sevenseg_capture.sv
// Seven-segment bus monitor: waits for the multiplexed display bus to settle, decodes the
// active digit's segment pattern, and keeps a per-digit register file of what is shown.
module sevenseg_capture #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            segs_n,
  input  logic                  dp_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     valid,
  output logic                  update,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int BW = DIGITS + 8;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] CAPTURE_CNT = 8'(STABLE_CYCLES - 1);

  typedef enum logic {SETTLE, HOLD} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   bus, bus_q;
  logic            primed;
  logic [7:0]      stable_cnt;
  logic            same;
  logic            capture;

  logic [3:0]      dec_val;
  logic            dec_blank;
  logic            dec_ok;
  logic [3:0]      low_cnt;
  logic [IW-1:0]   low_idx;

  assign bus  = {an_n, segs_n, dp_n};
  // primed forces the first edge after reset to count as a fresh word
  assign same = primed && (bus == bus_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q      <= '0;
      primed     <= 1'b0;
      stable_cnt <= '0;
      state      <= SETTLE;
    end else begin
      bus_q  <= bus;
      primed <= 1'b1;
      if (!same)
        stable_cnt <= '0;
      else if (stable_cnt != 8'hFF)
        stable_cnt <= stable_cnt + 8'd1;
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      SETTLE: begin
        if (same && stable_cnt == CAPTURE_CNT) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!same)
          state_next = SETTLE;
      end
      default: state_next = SETTLE;
    endcase
  end

  always_comb begin
    dec_val   = 4'h0;
    dec_blank = 1'b0;
    dec_ok    = 1'b1;
    case (segs_n)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_n[i]) begin
        low_cnt = low_cnt + 4'd1;
        low_idx = i[IW-1:0];
      end
    end
  end

  // A dark display still completes the settle window but writes nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      value    <= '0;
      blank    <= '0;
      dp       <= '0;
      valid    <= '0;
      update   <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      update <= 1'b0;
      err    <= 1'b0;
      if (capture) begin
        if (low_cnt >= 4'd2) begin
          err      <= 1'b1;
          err_code <= 2'b01;
        end else if (low_cnt == 4'd1) begin
          if (dec_ok) begin
            value[4*low_idx +: 4] <= dec_val;
            blank[low_idx]        <= dec_blank;
            dp[low_idx]           <= ~dp_n;
            valid[low_idx]        <= 1'b1;
            update                <= 1'b1;
          end else begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Randomised scoreboard bench for sevenseg_capture: a run-length display model predicts
// each capture event; a negedge monitor consumes the predictions and compares state.
module tb_sevenseg_capture;

  localparam int DIGITS = 8;
  localparam int STABLE = 4;
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int         edge_n;
    bit         is_err;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [DIGITS-1:0]    an_n;
  logic [6:0]           segs_n;
  logic                 dp_n;
  logic [4*DIGITS-1:0]  value;
  logic [DIGITS-1:0]    blank, dp, valid;
  logic                 update, err;
  logic [1:0]           err_code;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int upd_count = 0;
  int run = 0;
  logic [15:0] last_word;
  exp_t exp_q[$];
  exp_t mon_item;

  logic [4*DIGITS-1:0]  m_value;
  logic [DIGITS-1:0]    m_blank, m_dp, m_valid;
  logic [1:0]           m_code;

  sevenseg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .an_n(an_n), .segs_n(segs_n), .dp_n(dp_n),
    .value(value), .blank(blank), .dp(dp), .valid(valid),
    .update(update), .err(err), .err_code(err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word is present at exactly `cycles` rising edges; called from a negedge
  task automatic applyStimulus(input logic [7:0] a, input logic [6:0] s, input logic d, input int cycles);
    an_n   = a;
    segs_n = s;
    dp_n   = d;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic evaluateWord();
    int lows;
    int d;
    int found;
    exp_t e;
    lows  = $countones(~an_n);
    found = -1;
    d     = 0;
    e.edge_n = edge_no;
    e.is_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (!an_n[i]) d = i;
    for (int k = 0; k < 16; k++) if (PAT[k] == segs_n) found = k;
    if (lows >= 2) begin
      e.is_err = 1'b1;
      m_code   = 2'b01;
      exp_q.push_back(e);
    end else if (lows == 1) begin
      if (found >= 0 || segs_n == 7'h7F) begin
        m_value[4*d +: 4] = (found >= 0) ? 4'(found) : 4'h0;
        m_blank[d]        = (found < 0);
        m_dp[d]           = ~dp_n;
        m_valid[d]        = 1'b1;
        exp_q.push_back(e);
      end else begin
        e.is_err = 1'b1;
        m_code   = 2'b10;
        exp_q.push_back(e);
      end
    end
  endtask

  // Reference: a word is evaluated on the edge where it has been seen STABLE+1 times in a row
  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      run     = 0;
      m_value = '0;
      m_blank = '0;
      m_dp    = '0;
      m_valid = '0;
      m_code  = 2'b00;
    end else begin
      if (run > 0 && {an_n, segs_n, dp_n} == last_word) run++;
      else run = 1;
      last_word = {an_n, segs_n, dp_n};
      if (run == STABLE + 1) evaluateWord();
    end
  end

  always @(negedge clk) begin
    checkOutput("pulse_exclusive", 64'(update & err), 64'd0);
    if (exp_q.size() > 0 && exp_q[0].edge_n == edge_no) begin
      mon_item = exp_q.pop_front();
      checkOutput("pulse_update", 64'(update), 64'(!mon_item.is_err));
      checkOutput("pulse_err", 64'(err), 64'(mon_item.is_err));
    end else if (update || err) begin
      checkOutput("unexpected_pulse", {62'd0, update, err}, 64'd0);
    end
    checkOutput("value", 64'(value), 64'(m_value));
    checkOutput("blank", 64'(blank), 64'(m_blank));
    checkOutput("dp", 64'(dp), 64'(m_dp));
    checkOutput("valid", 64'(valid), 64'(m_valid));
    checkOutput("err_code", 64'(err_code), 64'(m_code));
    if (update) upd_count++;
  end

  initial begin
    int u0;
    int scan_idx [8] = '{0, 1, 2, 3, 10, 11, 14, 15};
    int sel;
    int dig;
    logic [7:0] a;
    logic [6:0] s;

    rst = 1'b1;
    an_n = 8'hFF; segs_n = 7'h7F; dp_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'hFF, 7'h7F, 1'b1, 20);
    checkOutput("idle_value", 64'(value), 64'd0);
    checkOutput("idle_valid", 64'(valid), 64'd0);
    checkOutput("idle_updates", 64'(upd_count), 64'd0);

    applyStimulus(8'hFE, 7'h24, 1'b0, 25);
    checkOutput("first_value", 64'(value[3:0]), 64'd2);
    checkOutput("first_dp", 64'(dp[0]), 64'd1);
    checkOutput("first_valid", 64'(valid), 64'h01);
    checkOutput("first_updates", 64'(upd_count), 64'd1);

    u0 = upd_count;
    for (int i = 0; i < DIGITS; i++)
      applyStimulus(~(8'b1 << i), PAT[scan_idx[i]], 1'b1, 10);
    checkOutput("scan_value", 64'(value), 64'hFEBA3210);
    checkOutput("scan_valid", 64'(valid), 64'hFF);
    checkOutput("scan_dp", 64'(dp), 64'h00);
    checkOutput("scan_updates", 64'(upd_count - u0), 64'd8);

    u0 = upd_count;
    applyStimulus(8'hF7, 7'h00, 1'b1, 3);
    applyStimulus(8'hF7, 7'h30, 1'b1, 10);
    checkOutput("glitch_digit3", 64'(value[15:12]), 64'd3);
    checkOutput("glitch_updates", 64'(upd_count - u0), 64'd1);

    applyStimulus(8'hFC, 7'h40, 1'b1, 8);
    checkOutput("multi_anode_code", 64'(err_code), 64'd1);
    applyStimulus(8'hFB, 7'h55, 1'b1, 8);
    checkOutput("bad_pattern_code", 64'(err_code), 64'd2);
    checkOutput("bad_pattern_valid2", 64'(valid[2]), 64'd1);
    applyStimulus(8'hDF, 7'h7F, 1'b0, 8);
    checkOutput("blank5", 64'(blank[5]), 64'd1);
    checkOutput("blank5_value", 64'(value[23:20]), 64'd0);
    checkOutput("blank5_valid", 64'(valid[5]), 64'd1);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      dig = $urandom_range(0, DIGITS - 1);
      a   = ~(8'b1 << dig);
      s   = PAT[$urandom_range(0, 15)];
      if (sel == 7) s = 7'h7F;
      if (sel == 8) s = 7'($urandom);
      if (sel == 9) a = 8'($urandom);
      applyStimulus(a, s, 1'($urandom), $urandom_range(1, 8));
    end

    applyStimulus(8'hEF, 7'h19, 1'b1, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_value", 64'(value), 64'd0);
    checkOutput("reset_flags", {blank, dp, valid}, 64'd0);
    checkOutput("reset_code", 64'(err_code), 64'd0);
    u0 = upd_count;
    applyStimulus(8'hEF, 7'h19, 1'b1, 4);
    checkOutput("post_reset_early", 64'(upd_count - u0), 64'd0);
    applyStimulus(8'hEF, 7'h19, 1'b1, 3);
    checkOutput("post_reset_capture", 64'(value[19:16]), 64'd4);
    checkOutput("post_reset_updates", 64'(upd_count - u0), 64'd1);

    repeat (3) @(negedge clk);
    checkOutput("pending_predictions", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive-side counterpart to the active-low seven-segment digit encoder: watches the multiplexed display bus (anodes, segments, decimal point) and reconstructs the per-digit value currently being displayed.
- Sits beside the display driver in board-level designs and benches as a self-check monitor.
- Filters scan transitions, decodes segment patterns back to hex/blank codes, keeps a per-digit register file and flags illegal bus states.

Parameters:
- DIGITS, 8, number of anode lines/digit positions (2..8).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- an_n  input  DIGITS  anode enables, active-low
- segs_n  input  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  input  1  decimal point, active-low
- value  output  4*DIGITS  decoded hex per digit; digit i at [4i+3:4i]
- blank  output  DIGITS  digit i last captured as blank (segs_n=7'h7F)
- dp  output  DIGITS  digit i decimal point lit at last capture
- valid  output  DIGITS  digit i captured at least once since reset
- update  output  1  one-cycle pulse on a successful capture
- err  output  1  one-cycle pulse on a rejected capture
- err_code  output  2  cause of the most recent err: 01 multiple anodes low, 10 undecodable pattern

Behaviour:
- Reset (synchronous, rst=1 at rising edge): value=0, blank=0, dp=0, valid=0, update=0, err=0, err_code=0; FSM to SETTLE, stability count 0. Reset wins over every other event, including a capture due on the same edge.
- Bus word B = {an_n, segs_n, dp_n}, registered every cycle into B_q. Count increments while B equals B_q and clears to 0 on any difference.
- FSM states:
  - SETTLE: waiting for B to hold steady.
  - HOLD: the captured word is still present; no further capture.
- SETTLE to HOLD:
  - Taken when B has been present at STABLE_CYCLES+1 consecutive rising edges.
  - With STABLE_CYCLES=4, a word first present at edges 1..5 is evaluated at edge 5. Resulting register writes, update and err are visible after edge 5; pulses are high for exactly that one cycle.
- HOLD to SETTLE: on any change of B. A glitch shorter than the window is ignored. If B returns to the previously held word, it re-settles and is captured again (update pulses again).
- Evaluation at capture:
  - All an_n bits 1 (display dark): no register change, no update, no err.
  - Exactly one an_n bit i low, segs_n decodable: value[i], blank[i], dp[i]=~dp_n written; valid[i]=1; update=1.
  - Exactly one an_n bit low, segs_n not in the table: no register change; err=1; err_code=10.
  - Two or more an_n bits low: no register change; err=1; err_code=01.
- err_code holds until the next err or reset.
- Decode table, segs_n hex to value: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
- Blank: 7F sets blank[i]=1 and value[i]=0. Every other pattern is undecodable.
- A blank digit is valid; dp is captured independently of blank.
- update and err are never high together.

Test Plan:
- Reset then idle with an_n=8'hFF (all dark) for 20 cycles → all outputs 0; update and err never asserted.
- an_n=8'hFE, segs_n=7'h24, dp_n=0, held 5 edges → after edge 5: value[3:0]=2, dp[0]=1, valid=8'h01, update high for one cycle only. Hold 20 more cycles → no further update.
- Scan digits 0..7 with patterns for 0,1,2,3,A,b,E,F, 10 cycles each, dp_n=1 → value=32'hFEBA3210, valid=8'hFF, dp=0, exactly 8 update pulses.
- Glitch: during a held word on digit 3, apply segs_n=7'h00 for 3 cycles, then restore 7'h30 → no capture of 8; value[15:12] remains 3. The restored word re-captures after 5 edges with one update pulse.
- Errors:
  - an_n=8'hFC with segs_n=7'h40 held → err pulse, err_code=01, registers unchanged.
  - an_n=8'hFB with segs_n=7'h55 held → err pulse, err_code=10, valid[2] unchanged.
  - segs_n=7'h7F on digit 5 → blank[5]=1, value[23:20]=0, valid[5]=1.
- Reset mid-operation: assert rst at the edge a capture is due → no update; all outputs 0 afterwards. The same word held after reset captures 5 edges after rst deasserts.
